// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes, serializer state encoding and frame-length helper.
// Used by both the TX and RX sides of the UART.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5,
    ST_BREAK  = 3'd6
  } tx_state_e;

  // Mode 2'b11 is reserved and behaves as no parity.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input logic par_en,
                                            input logic two_stop);
    return 1 + data_width + (par_en ? 1 : 0) + (two_stop ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Source-side and line-side signals of uart_tx_fifo; UART_TX_BREAK_EN adds send_break.
// master = data source / register block, slave = the transmitter.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_AW    = 4
);
  logic                  baud_clk;
  logic                  enable;
  logic [DATA_WIDTH-1:0] i_data;
  logic [1:0]            parity_mode;
  logic                  two_stop;
`ifdef UART_TX_BREAK_EN
  logic                  send_break;
`endif
  logic                  o_ready;
  logic                  o_overflow;
  logic [FIFO_AW:0]      o_fifo_count;
  logic                  o_busy;
  logic                  serial_out;

`ifdef UART_TX_BREAK_EN
  modport master (
    output baud_clk, enable, i_data, parity_mode, two_stop, send_break,
    input  o_ready, o_overflow, o_fifo_count, o_busy, serial_out
  );
  modport slave (
    input  baud_clk, enable, i_data, parity_mode, two_stop, send_break,
    output o_ready, o_overflow, o_fifo_count, o_busy, serial_out
  );
`else
  modport master (
    output baud_clk, enable, i_data, parity_mode, two_stop,
    input  o_ready, o_overflow, o_fifo_count, o_busy, serial_out
  );
  modport slave (
    input  baud_clk, enable, i_data, parity_mode, two_stop,
    output o_ready, o_overflow, o_fifo_count, o_busy, serial_out
  );
`endif

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and occupancy count; show-ahead read data.
// Pushes while full and pops while empty are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Flags are registered, so a push in the same cycle as a pop while full is still dropped.
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO feeding an LSB-first frame serializer (UART_TX_BREAK_EN adds line break).
// Line advances one bit per baud_clk strobe; pushes accepted while o_ready, else dropped with o_overflow.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic           clk,
  input logic           reset_n,
  uart_tx_fifo_if.slave bus
);

  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int IDXW    = $clog2(DATA_WIDTH);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  two_stop_q, two_stop_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q;
  logic                  load;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dat;
  logic [FIFO_AW:0]      fifo_count;

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_n),
    .push_i     (bus.enable),
    .push_dat_i (bus.i_data),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    par_bit_d  = par_bit_q;
    par_en_d   = par_en_q;
    two_stop_d = two_stop_q;
    tx_d       = tx_q;
    load       = 1'b0;
    fifo_pop   = 1'b0;

    if (bus.baud_clk) begin
      case (state_q)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (bus.send_break) begin
            tx_d    = 1'b0;
            state_d = ST_BREAK;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            tx_d = 1'b1;
          end
`else
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            tx_d = 1'b1;
          end
`endif
        end
        // The shift register always presents the next data bit at bit 0.
        ST_START: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA: begin
          if (idx_q != IDXW'(DATA_WIDTH-1)) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDXW'(1);
          end else if (par_en_q) begin
            tx_d    = par_bit_q;
            state_d = ST_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_STOP1;
          end
        end
        ST_PARITY: begin
          tx_d    = 1'b1;
          state_d = ST_STOP1;
        end
        ST_STOP1, ST_STOP2: begin
          if (state_q == ST_STOP1 && two_stop_q) begin
            tx_d    = 1'b1;
            state_d = ST_STOP2;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          if (bus.send_break) begin
            tx_d = 1'b0;
          end else begin
            tx_d       = 1'b1;
            two_stop_d = 1'b0;
            state_d    = ST_STOP1;
          end
        end
`endif
        default: begin
          tx_d    = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end

    // Frame configuration is captured only here, so mid-frame changes apply to the next word.
    if (load) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_dat;
      par_en_d   = parity_on(bus.parity_mode);
      par_bit_d  = (bus.parity_mode == PAR_ODD) ? ~^fifo_dat : ^fifo_dat;
      two_stop_d = bus.two_stop;
      tx_d       = 1'b0;
      state_d    = ST_START;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      par_bit_q  <= par_bit_d;
      par_en_q   <= par_en_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      ovf_q      <= bus.enable & fifo_full;
    end
  end

  assign bus.o_ready      = ~fifo_full;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_fifo_count = fifo_count;
  assign bus.o_busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.serial_out   = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queued words are decoded off serial_out tick by tick.
// Break scenario is included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    pm;
    logic          ts;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;

  uart_tx_fifo_if #(.DATA_WIDTH(DW), .FIFO_AW(AW)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  int          start_q[$];
  logic [15:0] cur_bits = '1;
  logic [15:0] last_frame = '1;
  int          rem = 0;
  int          pos = 0;
  int          frames_done = 0;
  int          tick_cnt = 0;
  bit          mon_en = 1'b1;
  bit          baud_run = 1'b0;
  logic        tick_at_edge = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) tick_at_edge <= bus.baud_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int build_frame(input exp_t e, output logic [15:0] b);
    int n;
    b = '1;
    b[0] = 1'b0;
    n = 1;
    for (int i = 0; i < DW; i++) begin
      b[n] = e.d[i];
      n++;
    end
    if (e.pm == PAR_EVEN) begin
      b[n] = ^e.d;
      n++;
    end else if (e.pm == PAR_ODD) begin
      b[n] = ~^e.d;
      n++;
    end
    b[n] = 1'b1;
    n++;
    if (e.ts) begin
      b[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  initial begin : baud_gen
    int cnt;
    cnt = 0;
    bus.baud_clk = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (baud_run) begin
        cnt = (cnt == 15) ? 0 : cnt + 1;
        bus.baud_clk = (cnt == 0);
      end else begin
        cnt = 0;
        bus.baud_clk = 1'b0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && tick_at_edge) begin
        tick_cnt++;
        if (mon_en) begin
          if (rem == 0) begin
            if (bus.serial_out == 1'b0) begin
              if (exp_q.size() == 0) begin
                chk("unexpected_start", 32'(bus.serial_out), 32'd1);
              end else begin
                e   = exp_q.pop_front();
                rem = build_frame(e, cur_bits) - 1;
                pos = 1;
                start_q.push_back(tick_cnt);
              end
            end
          end else begin
            chk("frame_bit", 32'(bus.serial_out), 32'(cur_bits[pos]));
            pos++;
            rem--;
            if (rem == 0) begin
              last_frame = cur_bits;
              frames_done++;
            end
          end
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] d, input logic [1:0] pm, input logic ts);
    exp_t e;
    @(posedge clk);
    #1;
    bus.enable      = 1'b1;
    bus.i_data      = d;
    bus.parity_mode = pm;
    bus.two_stop    = ts;
    if (bus.o_ready) begin
      e.d  = d;
      e.pm = pm;
      e.ts = ts;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus.o_busy || rem != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 20000), 32'd1);
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_at_edge && n < 64);
    if (!tick_at_edge) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.i_data      = '0;
    bus.parity_mode = PAR_NONE;
    bus.two_stop    = 1'b0;
`ifdef UART_TX_BREAK_EN
    bus.send_break  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line",  32'(bus.serial_out),   32'd1);
    chk("rst_busy",  32'(bus.o_busy),       32'd0);
    chk("rst_ready", 32'(bus.o_ready),      32'd1);
    chk("rst_ovf",   32'(bus.o_overflow),   32'd0);
    chk("rst_count", 32'(bus.o_fifo_count), 32'd0);
    reset_n  = 1'b1;
    baud_run = 1'b1;

    // Single 8N1 frame with a known line pattern
    push(8'hA5, PAR_NONE, 1'b0);
    wait_idle("t1_idle");
    chk("t1_frames", frames_done, 32'd1);
    chk("t1_line", 32'(last_frame[9:0]), 32'h34A);

    push(8'h07, PAR_EVEN, 1'b0);
    wait_idle("t2_even_idle");
    chk("t2_even_par", 32'(last_frame[9]), 32'd1);
    push(8'h07, PAR_ODD, 1'b0);
    wait_idle("t2_odd_idle");
    chk("t2_odd_par", 32'(last_frame[9]), 32'd0);
    chk("t2_frames", frames_done, 32'd3);

    // Back-to-back two-stop frames must start exactly 11 ticks apart
    push(8'h31, PAR_NONE, 1'b1);
    push(8'hC4, PAR_NONE, 1'b1);
    push(8'h9E, PAR_NONE, 1'b1);
    wait_idle("t3_idle");
    chk("t3_gap1", start_q[start_q.size()-2] - start_q[start_q.size()-3], 32'd11);
    chk("t3_gap2", start_q[start_q.size()-1] - start_q[start_q.size()-2], 32'd11);
    chk("t3_frames", frames_done, 32'd6);
    chk("t3_busy", 32'(bus.o_busy), 32'd0);

    baud_run = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < DEPTH; i++) push(8'(i * 7 + 3), PAR_NONE, 1'b0);
    chk("t4_ready", 32'(bus.o_ready), 32'd0);
    chk("t4_count_full", 32'(bus.o_fifo_count), 32'd16);
    bus.enable = 1'b1;
    bus.i_data = 8'hEE;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    chk("t4_ovf_pulse", 32'(bus.o_overflow), 32'd1);
    chk("t4_count_hold", 32'(bus.o_fifo_count), 32'd16);
    @(posedge clk);
    #1;
    chk("t4_ovf_clear", 32'(bus.o_overflow), 32'd0);
    baud_run = 1'b1;
    wait_idle("t4_idle");
    chk("t4_frames", frames_done, 32'd22);
    chk("t4_count_empty", 32'(bus.o_fifo_count), 32'd0);
    chk("t4_ready_again", 32'(bus.o_ready), 32'd1);

    // Asynchronous reset while data bit 3 is on the line
    push(8'h00, PAR_NONE, 1'b0);
    push(8'h00, PAR_NONE, 1'b0);
    n = 0;
    while (!(rem > 0 && pos == 5) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_bit3", 32'(n < 2000), 32'd1);
    chk("t5_pre_line", 32'(bus.serial_out), 32'd0);
    chk("t5_pre_count", 32'(bus.o_fifo_count), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_line", 32'(bus.serial_out), 32'd1);
    chk("t5_count", 32'(bus.o_fifo_count), 32'd0);
    chk("t5_busy", 32'(bus.o_busy), 32'd0);
    chk("t5_ready", 32'(bus.o_ready), 32'd1);
    rem = 0;
    pos = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    push(8'h3C, PAR_EVEN, 1'b1);
    wait_idle("t5_recover_idle");
    chk("t5_frames", frames_done, 32'd23);

`ifdef UART_TX_BREAK_EN
    baud_run = 1'b0;
    repeat (3) @(posedge clk);
    push(8'h55, PAR_NONE, 1'b1);
    mon_en         = 1'b0;
    bus.send_break = 1'b1;
    baud_run       = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_tick("brk_tick");
      chk("brk_low", 32'(bus.serial_out), 32'd0);
    end
    chk("brk_fifo_held", 32'(bus.o_fifo_count), 32'd1);
    bus.send_break = 1'b0;
    wait_tick("brk_stop_tick");
    chk("brk_stop", 32'(bus.serial_out), 32'd1);
    mon_en = 1'b1;
    wait_idle("brk_idle");
    chk("brk_frames", frames_done, 32'd24);
`endif

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
